// File: rtl/quadrature_step_generator.sv
// quadrature_step_generator: bus-programmable A/B quadrature edge source.
// Once started it emits REMAIN edges, one every PERIOD clocks, in the
// programmed direction, and tracks a signed 16-bit position.
// Optional feature macro: QUAD_STEP_GEN_IRQ_EN adds the irq output and the
// CTRL.IRQ_MASK bit.
module quadrature_step_generator #(
  parameter logic [15:0] PERIOD_RST = 16'd100,
  parameter logic [15:0] STEPS_RST  = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        A,
  output logic        B,
  output logic        busy,
  output logic        done
`ifdef QUAD_STEP_GEN_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] R_CTRL     = 4'h0;
  localparam logic [3:0] R_STEPS_L  = 4'h1;
  localparam logic [3:0] R_STEPS_H  = 4'h2;
  localparam logic [3:0] R_PERIOD_L = 4'h3;
  localparam logic [3:0] R_PERIOD_H = 4'h4;
  localparam logic [3:0] R_STATUS   = 4'h5;
  localparam logic [3:0] R_POS_L    = 4'h6;
  localparam logic [3:0] R_POS_H    = 4'h7;
  localparam logic [3:0] R_REM_L    = 4'h8;
  localparam logic [3:0] R_REM_H    = 4'h9;

  logic [0:0]  state;
  logic        ctrl_dir;
  logic [15:0] steps;
  logic [15:0] period;
  logic        act_dir;
  logic [15:0] work_period;
  logic [15:0] cnt;
  logic [15:0] remain;
  logic [15:0] pos;
  logic        zero_pend;
  logic        mask_bit;

  logic        addr_ok;
  logic        wr_en;
  logic        rd_en;
  logic        ctrl_wr;
  logic        start_req;
  logic        stop_req;
  logic        status_rd;
  logic        edge_tick;
  logic        run_start;
  logic        run_finish;
  logic [15:0] eff_period;
  logic [1:0]  ab_next;
  logic [7:0]  rd_mux;

  // Bus decode: any upper address bit set makes the access a no-op.
  assign addr_ok   = (addr[15:4] == 12'h000);
  assign wr_en     = cs & wr & addr_ok;
  assign rd_en     = cs & rd & addr_ok;
  assign ctrl_wr   = wr_en && (addr[3:0] == R_CTRL);
  assign stop_req  = ctrl_wr && data_in[2];
  assign start_req = ctrl_wr && data_in[0] && !data_in[2];
  assign status_rd = rd_en && (addr[3:0] == R_STATUS);

  // A zero period would never tick, so it runs at the fastest rate instead.
  assign eff_period = (period == 16'd0) ? 16'd1 : period;

  assign edge_tick  = (state == S_RUN) && (cnt == 16'd1);
  assign run_start  = (state == S_IDLE) && start_req && (steps != 16'd0);
  assign run_finish = edge_tick && !stop_req && (remain == 16'd1);

  // Gray step: forward A leads B (00,10,11,01), reverse walks the other way.
  assign ab_next = act_dir ? {B, ~A} : {~B, A};

`ifdef QUAD_STEP_GEN_IRQ_EN
  logic irq_mask;
  assign mask_bit = irq_mask;

  // CTRL.IRQ_MASK register.
  always_ff @(posedge clk) begin
    if (rst) irq_mask <= 1'b0;
    else if (ctrl_wr) irq_mask <= data_in[3];
  end

  // irq trails done by one clock, gated by the mask.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else irq <= done & irq_mask;
  end
`else
  assign mask_bit = 1'b0;
`endif

  // Config registers: only read back, latched into working copies on START.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_dir <= 1'b0;
      steps    <= STEPS_RST;
      period   <= PERIOD_RST;
    end else if (wr_en) begin
      case (addr[3:0])
        R_CTRL:     ctrl_dir     <= data_in[1];
        R_STEPS_L:  steps[7:0]   <= data_in;
        R_STEPS_H:  steps[15:8]  <= data_in;
        R_PERIOD_L: period[7:0]  <= data_in;
        R_PERIOD_H: period[15:8] <= data_in;
        default: ;
      endcase
    end
  end

  // Run FSM: period counter, phase stepping, position and remaining count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      act_dir     <= 1'b0;
      work_period <= 16'd1;
      cnt         <= 16'd1;
      remain      <= 16'd0;
      pos         <= 16'd0;
      A           <= 1'b0;
      B           <= 1'b0;
      zero_pend   <= 1'b0;
    end else begin
      zero_pend <= 1'b0;
      if (stop_req) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (state == S_IDLE) begin
        if (start_req) begin
          act_dir     <= data_in[1];
          work_period <= eff_period;
          cnt         <= eff_period;
          if (steps != 16'd0) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            remain <= steps;
          end else begin
            zero_pend <= 1'b1;
          end
        end
      end else if (edge_tick) begin
        cnt    <= work_period;
        {A, B} <= ab_next;
        remain <= remain - 16'd1;
        pos    <= pos + (act_dir ? 16'hFFFF : 16'h0001);
        if (remain == 16'd1) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Sticky done: completion sets it, a STATUS read or a new run clears it.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else if (zero_pend || run_finish) done <= 1'b1;
    else if (status_rd || run_start) done <= 1'b0;
  end

  // Register read mux; pulse bits of CTRL always read back as 0.
  always_comb begin
    rd_mux = 8'h00;
    case (addr[3:0])
      R_CTRL:     rd_mux = {4'b0000, mask_bit, 1'b0, ctrl_dir, 1'b0};
      R_STEPS_L:  rd_mux = steps[7:0];
      R_STEPS_H:  rd_mux = steps[15:8];
      R_PERIOD_L: rd_mux = period[7:0];
      R_PERIOD_H: rd_mux = period[15:8];
      R_STATUS:   rd_mux = {5'b00000, act_dir, done, busy};
      R_POS_L:    rd_mux = pos[7:0];
      R_POS_H:    rd_mux = pos[15:8];
      R_REM_L:    rd_mux = remain[7:0];
      R_REM_H:    rd_mux = remain[15:8];
      default:    rd_mux = 8'h00;
    endcase
  end

  // Registered read data; returns to zero on any cycle without a read.
  always_ff @(posedge clk) begin
    if (rst) data_out <= 8'h00;
    else if (rd_en) data_out <= rd_mux;
    else data_out <= 8'h00;
  end

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Directed bench for quadrature_step_generator: a register-access vector
// table plus hand-written run, abort, zero-step and reset sequences.
module tb_quadrature_step_generator;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        A;
  logic        B;
  logic        busy;
  logic        done;
`ifdef QUAD_STEP_GEN_IRQ_EN
  logic        irq;
  localparam logic [7:0] CTRL_RD = 8'h0A;
  localparam logic [7:0] ZCTRL   = 8'h09;
`else
  localparam logic [7:0] CTRL_RD = 8'h02;
  localparam logic [7:0] ZCTRL   = 8'h01;
`endif

  int n_vec = 0;
  int n_err = 0;

  quadrature_step_generator dut (
    .clk(clk), .rst(rst), .addr(addr), .cs(cs), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .A(A), .B(B),
    .busy(busy), .done(done)
`ifdef QUAD_STEP_GEN_IRQ_EN
    , .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
    string       nm;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; cs = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; cs = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    d = data_out;
    cs = 1'b0; rd = 1'b0; addr = 16'h0;
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [7:0] exp, input string nm);
    logic [7:0] d;
    bus_read(a, d);
    check(nm, {8'h00, d}, {8'h00, exp});
  endtask

  // Reference phase sequence, forward order 00,10,11,01.
  function automatic logic [1:0] next_ab(input logic [1:0] cur, input bit dir);
    logic [1:0] seq [4];
    logic [1:0] r;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    r = 2'bxx;
    for (int i = 0; i < 4; i++)
      if (seq[i] == cur) r = dir ? seq[(i + 3) % 4] : seq[(i + 1) % 4];
    return r;
  endfunction

  // Follows n edges, checking spacing, phase step and busy/done after each.
  task automatic follow_edges(input int n, input int first_per, input int per,
                              input bit dir, input bit ends, input string nm,
                              output int total);
    logic [1:0] prev;
    int cyc, want;
    total = 0;
    for (int e = 0; e < n; e++) begin
      prev = {A, B};
      cyc  = 0;
      want = (e == 0) ? first_per : per;
      while ({A, B} == prev && cyc <= want + 4) begin
        @(posedge clk); #1;
        cyc++;
      end
      total += cyc;
      check({nm, "_gap"}, 16'(cyc), 16'(want));
      check({nm, "_ab"}, {14'h0, A, B}, {14'h0, next_ab(prev, dir)});
      check({nm, "_busy_done"}, {14'h0, busy, done},
            (ends && e == n - 1) ? 16'h0001 : 16'h0002);
    end
  endtask

  initial begin
    int tot;
    logic [7:0] d;

    tbl[0]  = '{0, 16'h0003, 8'h00, 8'h64, "period_l_rst"};
    tbl[1]  = '{0, 16'h0004, 8'h00, 8'h00, "period_h_rst"};
    tbl[2]  = '{0, 16'h0006, 8'h00, 8'h00, "pos_l_rst"};
    tbl[3]  = '{0, 16'h0007, 8'h00, 8'h00, "pos_h_rst"};
    tbl[4]  = '{0, 16'h0005, 8'h00, 8'h00, "status_rst"};
    tbl[5]  = '{0, 16'h0001, 8'h00, 8'h00, "steps_l_rst"};
    tbl[6]  = '{1, 16'h0001, 8'hA5, 8'h00, "wr_steps_l"};
    tbl[7]  = '{0, 16'h0001, 8'h00, 8'hA5, "steps_l_rb"};
    tbl[8]  = '{1, 16'h0002, 8'h5A, 8'h00, "wr_steps_h"};
    tbl[9]  = '{0, 16'h0002, 8'h00, 8'h5A, "steps_h_rb"};
    tbl[10] = '{1, 16'h0000, 8'h0E, 8'h00, "wr_ctrl"};
    tbl[11] = '{0, 16'h0000, 8'h00, CTRL_RD, "ctrl_rb"};
    tbl[12] = '{1, 16'h000B, 8'hFF, 8'h00, "wr_unmapped"};
    tbl[13] = '{0, 16'h000B, 8'h00, 8'h00, "unmapped_rd"};
    tbl[14] = '{1, 16'h0013, 8'h77, 8'h00, "wr_high_addr"};
    tbl[15] = '{0, 16'h0003, 8'h00, 8'h64, "high_addr_ignored"};
    tbl[16] = '{0, 16'h0013, 8'h00, 8'h00, "high_addr_rd"};
    tbl[17] = '{0, 16'h0009, 8'h00, 8'h00, "remain_h_rst"};

    rst = 1'b1; addr = 16'h0; cs = 1'b0; rd = 1'b0; wr = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ab", {14'h0, A, B}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_done", {15'h0, done}, 16'h0000);
    check("rst_dout", {8'h00, data_out}, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].is_wr) bus_write(tbl[i].a, tbl[i].d);
      else begin
        bus_read(tbl[i].a, d);
        check(tbl[i].nm, {8'h00, d}, {8'h00, tbl[i].exp});
      end
    end

    @(posedge clk); #1;
    check("dout_idle_zero", {8'h00, data_out}, 16'h0000);

    // Simultaneous read and write returns the pre-write value.
    addr = 16'h0003; data_in = 8'h33; cs = 1'b1; rd = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    check("rdwr_old_val", {8'h00, data_out}, 16'h0064);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    read_chk(16'h0003, 8'h33, "rdwr_new_val");

    // Forward run: 20 edges at 100 clocks.
    bus_write(16'h1, 8'd20); bus_write(16'h2, 8'h00);
    bus_write(16'h3, 8'd100); bus_write(16'h4, 8'h00);
    bus_write(16'h0, 8'h01);
    check("fwd_busy", {15'h0, busy}, 16'h0001);
    follow_edges(20, 100, 100, 1'b0, 1'b1, "fwd", tot);
    check("fwd_total", 16'(tot), 16'd2000);
    check("fwd_final_ab", {14'h0, A, B}, 16'h0000);
    read_chk(16'h6, 8'h14, "fwd_pos_l");
    read_chk(16'h7, 8'h00, "fwd_pos_h");
    read_chk(16'h8, 8'h00, "fwd_rem_l");
    read_chk(16'h5, 8'h02, "fwd_status");
    check("fwd_done_cleared", {15'h0, done}, 16'h0000);
    read_chk(16'h5, 8'h00, "fwd_status2");

    // Reverse run back to position 0.
    bus_write(16'h0, 8'h03);
    follow_edges(20, 100, 100, 1'b1, 1'b1, "rev", tot);
    read_chk(16'h6, 8'h00, "rev_pos_l");
    read_chk(16'h7, 8'h00, "rev_pos_h");
    read_chk(16'h5, 8'h06, "rev_status");

    // Zero steps: done without busy or A/B motion.
    bus_write(16'h1, 8'h00);
    bus_write(16'h0, ZCTRL);
    check("zero_busy", {15'h0, busy}, 16'h0000);
    @(posedge clk); #1;
    check("zero_busy_done", {14'h0, busy, done}, 16'h0001);
    check("zero_ab", {14'h0, A, B}, 16'h0000);
`ifdef QUAD_STEP_GEN_IRQ_EN
    @(posedge clk); #1;
    check("irq_set", {15'h0, irq}, 16'h0001);
`endif
    read_chk(16'h5, 8'h02, "zero_status");
`ifdef QUAD_STEP_GEN_IRQ_EN
    @(posedge clk); #1;
    check("irq_clear", {15'h0, irq}, 16'h0000);
`endif

    // Abort after 7 edges; START combined with STOP is ignored.
    bus_write(16'h1, 8'd20); bus_write(16'h3, 8'd10);
    bus_write(16'h0, 8'h01);
    follow_edges(7, 10, 10, 1'b0, 1'b0, "abort", tot);
    bus_write(16'h0, 8'h05);
    check("abort_busy_done", {14'h0, busy, done}, 16'h0000);
    check("abort_ab", {14'h0, A, B}, 16'h0001);
    repeat (30) @(posedge clk);
    #1;
    check("abort_hold_ab", {14'h0, A, B}, 16'h0001);
    check("abort_hold_busy", {15'h0, busy}, 16'h0000);
    read_chk(16'h6, 8'h07, "abort_pos_l");
    read_chk(16'h8, 8'h0D, "abort_rem_l");
    read_chk(16'h9, 8'h00, "abort_rem_h");
    read_chk(16'h5, 8'h00, "abort_status");

    // START while busy is ignored, config writes do not disturb the run.
    bus_write(16'h1, 8'd4);
    bus_write(16'h0, 8'h01);
    follow_edges(2, 10, 10, 1'b0, 1'b0, "ign_a", tot);
    bus_write(16'h1, 8'd50);
    bus_write(16'h0, 8'h03);
    follow_edges(2, 8, 10, 1'b0, 1'b1, "ign_b", tot);
    read_chk(16'h6, 8'h0B, "ign_pos_l");
    read_chk(16'h5, 8'h02, "ign_status");

    // PERIOD=0 runs one edge per clock.
    bus_write(16'h3, 8'h00);
    bus_write(16'h1, 8'd4);
    bus_write(16'h0, 8'h01);
    follow_edges(4, 1, 1, 1'b0, 1'b1, "p0", tot);
    read_chk(16'h6, 8'h0F, "p0_pos_l");

    // Reset in the middle of a run.
    bus_write(16'h3, 8'd10);
    bus_write(16'h1, 8'd20);
    bus_write(16'h0, 8'h01);
    follow_edges(3, 10, 10, 1'b0, 1'b0, "pre_rst", tot);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ab", {14'h0, A, B}, 16'h0000);
    check("midrst_busy_done", {14'h0, busy, done}, 16'h0000);
    read_chk(16'h3, 8'h64, "midrst_period_l");
    read_chk(16'h6, 8'h00, "midrst_pos_l");
    read_chk(16'h1, 8'h00, "midrst_steps_l");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
